// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// Module   : timer_counter
// Purpose  : Bus-mapped 32-bit down-counter with one-shot / auto-reload modes
//            and a maskable interrupt towards HWInt[0].
// Revision : 1.0 - initial release
// ============================================================================
module timer_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0] C_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] C_ADDR_PRESET = 2'd1;
  localparam logic [1:0] C_ADDR_COUNT  = 2'd2;
  localparam logic [1:0] C_MODE_RELOAD = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        w_ctrl_wr;
  logic        w_preset_wr;

  assign w_ctrl_wr   = we && (addr == C_ADDR_CTRL);
  assign w_preset_wr = we && (addr == C_ADDR_PRESET);

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    mode_d     = mode_q;
    im_d       = im_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      S_IDLE: begin
        if (en_q) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // A count of 0 or 1 both expire here, so COUNT never wraps.
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = S_INT;
        end
      end
      S_INT: begin
        state_d = S_IDLE;
        if (mode_q == C_MODE_RELOAD) begin
          irq_flag_d = 1'b0;
        end else begin
          en_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_preset_wr) begin
      preset_d = wdata;
    end

    // Bus writes to CTRL override the FSM's own EN clear and always drop the flag.
    if (w_ctrl_wr) begin
      en_d       = wdata[0];
      mode_d     = wdata[2:1];
      im_d       = wdata[3];
      irq_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      mode_q     <= 2'd0;
      im_q       <= 1'b0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      C_ADDR_CTRL:   rdata = {28'd0, im_q, mode_q, en_q};
      C_ADDR_PRESET: rdata = preset_q;
      C_ADDR_COUNT:  rdata = count_q;
      default:       rdata = 32'd0;
    endcase
  end

  assign irq = irq_flag_q & im_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_counter
// Purpose  : Directed self-checking bench for timer_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  timer_counter dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled around the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
    wdata = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    we  = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      checks++;
      if (v !== 32'd0) begin
        failures++;
        $display("FAIL reset_rd addr=%0d got=%h exp=%h", a, v, 32'd0);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    bus_wr(2'd2, 32'h1234_5678);
    rd(2'd2, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL count_ro got=%h exp=%h", v, 32'd0);
    end
    bus_wr(2'd3, 32'hDEAD_BEEF);
    rd(2'd3, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL addr3_rd got=%h exp=%h", v, 32'd0);
    end
    bus_wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, v);
    checks++;
    if (v !== 32'h0000_000F) begin
      failures++;
      $display("FAIL ctrl_mask got=%h exp=%h", v, 32'h0000_000F);
    end
    do_reset();
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    do_reset();
    bus_wr(2'd1, 32'd5);
    bus_wr(2'd0, 32'h9);          // edge t
    tick(2);                      // after t+2
    for (int i = 0; i < 5; i++) begin
      rd(2'd2, v);
      checks++;
      if (v !== 32'(5 - i)) begin
        failures++;
        $display("FAIL os_count step=%0d got=%0d exp=%0d", i, v, 5 - i);
      end
      checks++;
      if (irq !== 1'b0) begin
        failures++;
        $display("FAIL os_irq_early step=%0d got=%b exp=0", i, irq);
      end
      tick(1);
    end
    rd(2'd2, v);                  // after t+7
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL os_count_zero got=%0d exp=0", v);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL os_irq_rise got=%b exp=1", irq);
    end
    tick(1);                      // after t+8
    rd(2'd0, v);
    checks++;
    if (v !== 32'h8) begin
      failures++;
      $display("FAIL os_ctrl_en_clr got=%h exp=%h", v, 32'h8);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++;
      if (irq !== 1'b1) begin
        failures++;
        $display("FAIL os_irq_hold cyc=%0d got=%b exp=1", i, irq);
      end
    end
    bus_wr(2'd0, 32'h0);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL os_irq_clear got=%b exp=0", irq);
    end
  endtask

  task automatic test_reload;
    logic [31:0] v;
    logic        exp;
    do_reset();
    bus_wr(2'd1, 32'd3);
    bus_wr(2'd0, 32'hB);          // edge t
    for (int k = 1; k <= 24; k++) begin
      tick(1);                    // after t+k
      exp = (k >= 5) && (((k - 5) % 6) == 0);
      checks++;
      if (irq !== exp) begin
        failures++;
        $display("FAIL rl_irq k=%0d got=%b exp=%b", k, irq, exp);
      end
    end
    rd(2'd0, v);
    checks++;
    if (v !== 32'hB) begin
      failures++;
      $display("FAIL rl_ctrl got=%h exp=%h", v, 32'hB);
    end
  endtask

  task automatic test_masked;
    logic [31:0] v;
    do_reset();
    bus_wr(2'd1, 32'd2);
    bus_wr(2'd0, 32'h1);          // edge t
    tick(6);                      // after t+6
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL mk_irq got=%b exp=0", irq);
    end
    rd(2'd2, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL mk_count got=%0d exp=0", v);
    end
    rd(2'd0, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL mk_ctrl got=%h exp=%h", v, 32'h0);
    end
    bus_wr(2'd0, 32'h8);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (irq !== 1'b0) begin
        failures++;
        $display("FAIL mk_irq_unmask cyc=%0d got=%b exp=0", i, irq);
      end
      tick(1);
    end
  endtask

  task automatic test_preset_midcount;
    logic [31:0] v;
    do_reset();
    bus_wr(2'd1, 32'd10);
    bus_wr(2'd0, 32'hB);          // edge t
    tick(6);                      // after t+6
    rd(2'd2, v);
    checks++;
    if (v !== 32'd6) begin
      failures++;
      $display("FAIL pm_count6 got=%0d exp=6", v);
    end
    bus_wr(2'd1, 32'd2);          // edge t+7
    tick(4);                      // after t+11
    rd(2'd2, v);
    checks++;
    if (v !== 32'd1) begin
      failures++;
      $display("FAIL pm_count1 got=%0d exp=1", v);
    end
    tick(1);                      // after t+12
    rd(2'd2, v);
    checks++;
    if (v !== 32'd0 || irq !== 1'b1) begin
      failures++;
      $display("FAIL pm_expire count=%0d irq=%b exp count=0 irq=1", v, irq);
    end
    tick(3);                      // after t+15
    rd(2'd2, v);
    checks++;
    if (v !== 32'd2) begin
      failures++;
      $display("FAIL pm_reload got=%0d exp=2", v);
    end
  endtask

  task automatic test_freeze;
    logic [31:0] v;
    do_reset();
    bus_wr(2'd1, 32'd8);
    bus_wr(2'd0, 32'h1);          // edge t
    tick(5);                      // after t+5
    rd(2'd2, v);
    checks++;
    if (v !== 32'd5) begin
      failures++;
      $display("FAIL fz_pre got=%0d exp=5", v);
    end
    bus_wr(2'd0, 32'h0);          // edge t+6
    for (int i = 0; i < 11; i++) begin
      rd(2'd2, v);
      checks++;
      if (v !== 32'd4) begin
        failures++;
        $display("FAIL fz_hold cyc=%0d got=%0d exp=4", i, v);
      end
      tick(1);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    do_reset();
    // Rewriting EN=1 mid-count must not restart the count.
    bus_wr(2'd1, 32'd6);
    bus_wr(2'd0, 32'h1);          // edge t
    tick(3);                      // after t+3, COUNT=5
    bus_wr(2'd0, 32'h1);          // edge t+4
    rd(2'd2, v);
    checks++;
    if (v !== 32'd4) begin
      failures++;
      $display("FAIL bb_no_restart got=%0d exp=4", v);
    end
    // PRESET written during LOAD: the old value is loaded.
    do_reset();
    bus_wr(2'd1, 32'd4);
    bus_wr(2'd0, 32'h1);          // edge t
    tick(1);                      // after t+1, in LOAD
    bus_wr(2'd1, 32'd9);          // edge t+2
    rd(2'd2, v);
    checks++;
    if (v !== 32'd4) begin
      failures++;
      $display("FAIL bb_load_old got=%0d exp=4", v);
    end
    rd(2'd1, v);
    checks++;
    if (v !== 32'd9) begin
      failures++;
      $display("FAIL bb_preset_new got=%0d exp=9", v);
    end
    // PRESET=0 expires like PRESET=1; bus CTRL write in INT wins over EN clear.
    do_reset();
    bus_wr(2'd1, 32'd0);
    bus_wr(2'd0, 32'h9);          // edge t
    tick(2);                      // after t+2
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL bb_p0_early got=%b exp=0", irq);
    end
    tick(1);                      // after t+3
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL bb_p0_irq got=%b exp=1", irq);
    end
    bus_wr(2'd0, 32'h9);          // edge t+4, FSM in INT
    rd(2'd0, v);
    checks++;
    if (v !== 32'h9 || irq !== 1'b0) begin
      failures++;
      $display("FAIL bb_int_wr ctrl=%h irq=%b exp ctrl=9 irq=0", v, irq);
    end
    tick(3);                      // after t+7
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL bb_rerun_irq got=%b exp=1", irq);
    end
  endtask

  task automatic test_reset_midcount;
    logic [31:0] v;
    do_reset();
    bus_wr(2'd1, 32'd7);
    bus_wr(2'd0, 32'hB);
    tick(4);
    rd(2'd2, v);
    checks++;
    if (v !== 32'd5) begin
      failures++;
      $display("FAIL rm_pre got=%0d exp=5", v);
    end
    // Reset and a CTRL write on the same edge: reset wins.
    rst   = 1'b1;
    addr  = 2'd0;
    wdata = 32'hF;
    we    = 1'b1;
    tick(1);
    rst   = 1'b0;
    we    = 1'b0;
    for (int a = 0; a < 3; a++) begin
      rd(a[1:0], v);
      checks++;
      if (v !== 32'd0) begin
        failures++;
        $display("FAIL rm_rd addr=%0d got=%h exp=0", a, v);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL rm_irq got=%b exp=0", irq);
    end
    tick(5);
    rd(2'd2, v);
    checks++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL rm_idle count=%0d irq=%b exp 0/0", v, irq);
    end
  endtask

  initial begin
    rst   = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = 32'd0;
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_reload();
    test_masked();
    test_preset_midcount();
    test_freeze();
    test_back_to_back();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
